// File: rtl/d_cache_assoc.sv
// d_cache_assoc: write-back, write-allocate 1/2-way set-associative data cache with true-LRU and a post-reset
// invalidate sweep; define DCACHE_STATS_EN to add saturating o_Hit_Count/o_Miss_Count outputs.
module d_cache_assoc #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 22,
    parameter int OFFSET_WIDTH  = 2,
    parameter int INDEX_WIDTH   = 6,
    parameter int WAYS          = 2,
    parameter int TAG_WIDTH     = ADDRESS_WIDTH - INDEX_WIDTH - OFFSET_WIDTH
) (
    input  logic                     i_Clk,
    input  logic                     i_Reset,
    input  logic                     i_Valid,
    input  logic [ADDRESS_WIDTH-1:0] i_Address,
    input  logic                     i_Read_Write_n,
    input  logic [DATA_WIDTH-1:0]    i_Write_Data,
    output logic                     o_Ready,
    output logic                     o_Valid,
    output logic [DATA_WIDTH-1:0]    o_Data,
`ifdef DCACHE_STATS_EN
    output logic [31:0]              o_Hit_Count,
    output logic [31:0]              o_Miss_Count,
`endif
    output logic                     o_MEM_Valid,
    output logic                     o_MEM_Read_Write_n,
    output logic [ADDRESS_WIDTH:0]   o_MEM_Address,
    output logic [DATA_WIDTH-1:0]    o_MEM_Data,
    input  logic                     i_MEM_Valid,
    input  logic                     i_MEM_Data_Read,
    input  logic                     i_MEM_Last,
    input  logic [DATA_WIDTH-1:0]    i_MEM_Data
);
    localparam int SETS = 1 << INDEX_WIDTH;
    localparam int LINE = 1 << OFFSET_WIDTH;
    typedef enum logic [2:0] {INIT, READY, WRITEOUT, POPULATE, PAUSE} state_t;
    state_t state, next_state;
    logic [DATA_WIDTH-1:0]    data_mem [WAYS][SETS*LINE];
    logic [TAG_WIDTH-1:0]     tag_mem [WAYS][SETS];
    logic [WAYS-1:0]          valid_mem [SETS];
    logic [WAYS-1:0]          dirty_mem [SETS];
    logic [TAG_WIDTH-1:0]     tag, r_tag;
    logic [INDEX_WIDTH-1:0]   idx, r_idx, sweep;
    logic [OFFSET_WIDTH-1:0]  off, r_off, gen_count;
    logic [ADDRESS_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0]    r_data, data_q;
    logic [WAYS-1:0]          hit_w;
    logic r_rw, r_way, valid_q, lru_rd, hit, hit_way, victim, accept, acc_hit, acc_miss;
    assign {tag, idx, off} = i_Address;
    assign {r_tag, r_idx, r_off} = r_addr;
    for (genvar w = 0; w < WAYS; w++) begin : g_hit
        assign hit_w[w] = valid_mem[idx][w] && tag_mem[w][idx] == tag;
    end
    assign hit     = |hit_w;
    assign hit_way = WAYS == 2 && hit_w[WAYS-1];
    // Fill an empty way before evicting; only a full set consults LRU.
    assign victim   = !valid_mem[idx][0] ? 1'b0 : (WAYS == 2 && !valid_mem[idx][WAYS-1]) ? 1'b1 : lru_rd;
    assign accept   = state == READY && i_Valid;
    assign acc_hit  = accept && hit;
    assign acc_miss = accept && !hit;
    generate
        if (WAYS == 2) begin : g_lru
            logic lru_mem [SETS];
            always_ff @(posedge i_Clk) begin
                if (!i_Reset) begin
                    if (state == INIT) lru_mem[sweep] <= 1'b0;
                    else if (acc_hit) lru_mem[idx] <= !hit_way;
                    else if (state == POPULATE && i_MEM_Valid && i_MEM_Last) lru_mem[r_idx] <= !r_way;
                end
            end
            assign lru_rd = lru_mem[idx];
        end else begin : g_no_lru
            assign lru_rd = 1'b0;
        end
    endgenerate
    always_ff @(posedge i_Clk) state <= i_Reset ? INIT : next_state;
    always_comb begin
        next_state = state;
        case (state)
            INIT:     next_state = sweep == '1 ? READY : INIT;
            READY:    next_state = acc_miss ? (dirty_mem[idx][victim] ? WRITEOUT : POPULATE) : READY;
            WRITEOUT: next_state = i_MEM_Data_Read && i_MEM_Last ? POPULATE : WRITEOUT;
            POPULATE: next_state = i_MEM_Valid && i_MEM_Last ? PAUSE : POPULATE;
            default:  next_state = READY;
        endcase
    end
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            sweep     <= '0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            gen_count <= '0;
        end else begin
            valid_q <= acc_hit;
            case (state)
                INIT: begin
                    valid_mem[sweep] <= '0;
                    dirty_mem[sweep] <= '0;
                    sweep <= sweep + 1'b1;
                end
                READY: begin
                    if (acc_hit && i_Read_Write_n) data_q <= data_mem[hit_way][{idx, off}];
                    else if (acc_hit) begin
                        data_mem[hit_way][{idx, off}] <= i_Write_Data;
                        dirty_mem[idx][hit_way] <= 1'b1;
                    end else if (accept) begin
                        r_addr    <= i_Address;
                        r_data    <= i_Write_Data;
                        r_rw      <= i_Read_Write_n;
                        r_way     <= victim;
                        gen_count <= '0;
                    end
                end
                WRITEOUT: begin
                    if (i_MEM_Data_Read && i_MEM_Last) begin
                        dirty_mem[r_idx][r_way] <= 1'b0;
                        gen_count <= '0;
                    end else if (i_MEM_Data_Read && gen_count != '1) gen_count <= gen_count + 1'b1;
                end
                POPULATE: begin
                    if (i_MEM_Valid) begin
                        // A store miss merges its word over the fill beat at the requested offset.
                        data_mem[r_way][{r_idx, gen_count}] <= !r_rw && gen_count == r_off ? r_data : i_MEM_Data;
                        if (r_rw && gen_count == r_off) data_q <= i_MEM_Data;
                        gen_count <= gen_count + 1'b1;
                        if (i_MEM_Last) begin
                            tag_mem[r_way][r_idx]   <= r_tag;
                            valid_mem[r_idx][r_way] <= 1'b1;
                            dirty_mem[r_idx][r_way] <= !r_rw;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
`ifdef DCACHE_STATS_EN
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            o_Hit_Count  <= '0;
            o_Miss_Count <= '0;
        end else begin
            if (acc_hit && o_Hit_Count != '1) o_Hit_Count <= o_Hit_Count + 32'd1;
            if (acc_miss && o_Miss_Count != '1) o_Miss_Count <= o_Miss_Count + 32'd1;
        end
    end
`endif
    assign o_Ready            = state == READY;
    assign o_Valid            = valid_q || state == PAUSE;
    assign o_Data             = data_q;
    assign o_MEM_Valid        = state == WRITEOUT || state == POPULATE;
    assign o_MEM_Read_Write_n = state != WRITEOUT;
    assign o_MEM_Address      = state == WRITEOUT ? {tag_mem[r_way][r_idx], r_idx, {(OFFSET_WIDTH+1){1'b0}}} :
                                state == POPULATE ? {r_tag, r_idx, {(OFFSET_WIDTH+1){1'b0}}} : '0;
    assign o_MEM_Data         = state == WRITEOUT ? data_mem[r_way][{r_idx, gen_count}] : '0;
endmodule
